// File: rtl/tick_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tick_sched_ctrl
// Description : Programs a tick timer over its register bus, then round-robins
//               the selected task on every serviced timer interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_sched_ctrl #(
    parameter int NUM_TASKS = 4,
    parameter int TID_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [15:0]          period,
    input  logic [7:0]           prescale,
    input  logic [NUM_TASKS-1:0] task_mask,
    output logic                 tmr_cs,
    output logic                 tmr_write,
    output logic [2:0]           tmr_addr,
    output logic [7:0]           tmr_wdata,
    input  logic                 tmr_irq,
    output logic [TID_W-1:0]     task_id,
    output logic                 task_switch,
    output logic                 running,
    output logic [15:0]          tick_count,
    output logic                 cfg_err
);

    localparam logic [3:0] c_st_idle   = 4'd0;
    localparam logic [3:0] c_st_w_rst  = 4'd1;
    localparam logic [3:0] c_st_w_pre  = 4'd2;
    localparam logic [3:0] c_st_w_cmpl = 4'd3;
    localparam logic [3:0] c_st_w_cmph = 4'd4;
    localparam logic [3:0] c_st_w_en   = 4'd5;
    localparam logic [3:0] c_st_run    = 4'd6;
    localparam logic [3:0] c_st_ack    = 4'd7;
    localparam logic [3:0] c_st_switch = 4'd8;
    localparam logic [3:0] c_st_w_off  = 4'd9;

    logic [3:0]       r_state;
    logic [15:0]      r_period;
    logic [7:0]       r_prescale;
    logic [TID_W-1:0] r_task_id;
    logic [15:0]      r_tick_count;
    logic             r_task_switch;
    logic             r_cfg_err;
    logic             r_stop_pend;

    logic [TID_W-1:0] w_next_tid;
    logic [TID_W-1:0] w_cand;
    logic             w_found;
    logic             w_latch_state;
    logic             w_bus_cs;
    logic [2:0]       w_bus_addr;
    logic [7:0]       w_bus_data;

    // Round-robin search upward from the current task; no other candidate means hold.
    always_comb begin
        w_next_tid = r_task_id;
        w_found    = 1'b0;
        w_cand     = '0;
        for (int i = 1; i < NUM_TASKS; i++) begin
            w_cand = TID_W'((int'(r_task_id) + i) % NUM_TASKS);
            if (!w_found && task_mask[w_cand]) begin
                w_next_tid = w_cand;
                w_found    = 1'b1;
            end
        end
    end

    always_comb begin
        w_latch_state = 1'b0;
        case (r_state)
            c_st_w_rst, c_st_w_pre, c_st_w_cmpl, c_st_w_cmph, c_st_w_en,
            c_st_ack, c_st_switch: w_latch_state = 1'b1;
            default:               w_latch_state = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_period      <= '0;
            r_prescale    <= '0;
            r_task_id     <= '0;
            r_tick_count  <= '0;
            r_task_switch <= 1'b0;
            r_cfg_err     <= 1'b0;
            r_stop_pend   <= 1'b0;
        end else begin
            r_task_switch <= 1'b0;
            r_cfg_err     <= 1'b0;
            if (stop && w_latch_state) begin
                r_stop_pend <= 1'b1;
            end
            // A latched stop lets the state in progress finish, then diverts to W_OFF.
            case (r_state)
                c_st_idle: begin
                    r_stop_pend <= 1'b0;
                    if (start && !stop) begin
                        if (period != 16'd0) begin
                            r_period     <= period;
                            r_prescale   <= prescale;
                            r_tick_count <= '0;
                            r_state      <= c_st_w_rst;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                c_st_w_rst:  r_state <= r_stop_pend ? c_st_w_off : c_st_w_pre;
                c_st_w_pre:  r_state <= r_stop_pend ? c_st_w_off : c_st_w_cmpl;
                c_st_w_cmpl: r_state <= r_stop_pend ? c_st_w_off : c_st_w_cmph;
                c_st_w_cmph: r_state <= r_stop_pend ? c_st_w_off : c_st_w_en;
                c_st_w_en:   r_state <= r_stop_pend ? c_st_w_off : c_st_run;
                c_st_run: begin
                    if (stop || r_stop_pend) begin
                        r_state <= c_st_w_off;
                    end else if (tmr_irq) begin
                        r_state <= c_st_ack;
                    end
                end
                c_st_ack:    r_state <= r_stop_pend ? c_st_w_off : c_st_switch;
                c_st_switch: begin
                    r_tick_count  <= r_tick_count + 16'd1;
                    r_task_id     <= w_next_tid;
                    r_task_switch <= w_found;
                    r_state       <= r_stop_pend ? c_st_w_off : c_st_run;
                end
                c_st_w_off: begin
                    r_stop_pend <= 1'b0;
                    r_state     <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    always_comb begin
        w_bus_cs   = 1'b1;
        w_bus_addr = 3'd0;
        w_bus_data = 8'h00;
        case (r_state)
            c_st_w_rst:  begin w_bus_addr = 3'd0; w_bus_data = 8'h08;            end
            c_st_w_pre:  begin w_bus_addr = 3'd6; w_bus_data = r_prescale;       end
            c_st_w_cmpl: begin w_bus_addr = 3'd4; w_bus_data = r_period[7:0];    end
            c_st_w_cmph: begin w_bus_addr = 3'd5; w_bus_data = r_period[15:8];   end
            c_st_w_en:   begin w_bus_addr = 3'd0; w_bus_data = 8'h07;            end
            c_st_ack:    begin w_bus_addr = 3'd1; w_bus_data = 8'h01;            end
            c_st_w_off:  begin w_bus_addr = 3'd0; w_bus_data = 8'h00;            end
            default:     w_bus_cs = 1'b0;
        endcase
    end

    assign tmr_cs      = w_bus_cs;
    assign tmr_write   = w_bus_cs;
    assign tmr_addr    = w_bus_addr;
    assign tmr_wdata   = w_bus_data;
    assign task_id     = r_task_id;
    assign task_switch = r_task_switch;
    assign tick_count  = r_tick_count;
    assign cfg_err     = r_cfg_err;
    assign running     = (r_state == c_st_run) || (r_state == c_st_ack) ||
                         (r_state == c_st_switch);

endmodule
`default_nettype wire

// File: tb/tb_tick_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tick_sched_ctrl
// Description : Scoreboard bench for tick_sched_ctrl bus writes and task switches.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_sched_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] period = '0;
    logic [7:0]  prescale = '0;
    logic [3:0]  task_mask = '0;
    logic        tmr_irq = 1'b0;
    logic        tmr_cs;
    logic        tmr_write;
    logic [2:0]  tmr_addr;
    logic [7:0]  tmr_wdata;
    logic [1:0]  task_id;
    logic        task_switch;
    logic        running;
    logic [15:0] tick_count;
    logic        cfg_err;

    tick_sched_ctrl #(.NUM_TASKS(4), .TID_W(2)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .period      (period),
        .prescale    (prescale),
        .task_mask   (task_mask),
        .tmr_cs      (tmr_cs),
        .tmr_write   (tmr_write),
        .tmr_addr    (tmr_addr),
        .tmr_wdata   (tmr_wdata),
        .tmr_irq     (tmr_irq),
        .task_id     (task_id),
        .task_switch (task_switch),
        .running     (running),
        .tick_count  (tick_count),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
        int         cyc;   // -1: cycle not checked
    } bus_t;

    bus_t       bus_q[$];
    logic [1:0] sw_q[$];
    bus_t       mon_e;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         n_cfg = 0;
    int         n_sw = 0;
    int         n_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push_bus(input logic [2:0] a, input logic [7:0] d, input int c);
        bus_t e;
        e.addr = a;
        e.data = d;
        e.cyc  = c;
        bus_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (tmr_cs || tmr_write) begin
                if (bus_q.size() == 0) begin
                    chk("bus_unexpected", {19'd0, tmr_cs, tmr_write, tmr_addr, tmr_wdata}, 32'd0);
                end else begin
                    mon_e = bus_q.pop_front();
                    chk("bus_wr", {19'd0, tmr_cs, tmr_write, tmr_addr, tmr_wdata},
                        {19'd0, 2'b11, mon_e.addr, mon_e.data});
                    if (mon_e.cyc >= 0) chk("bus_cyc", cyc, mon_e.cyc);
                end
            end
            if (task_switch) begin
                n_sw++;
                if (sw_q.size() == 0) chk("switch_unexpected", {30'd0, task_id}, 32'hFFFF_FFFF);
                else chk("switch_tid", {30'd0, task_id}, {30'd0, sw_q.pop_front()});
            end
            if (cfg_err) n_cfg++;
            if (running) n_run++;
        end
    end

    task automatic wait_ack();
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tmr_cs && tmr_addr == 3'd1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("ack_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic do_tick(input bit exp_sw, input logic [1:0] exp_tid);
        if (exp_sw) sw_q.push_back(exp_tid);
        push_bus(3'd1, 8'h01, -1);
        tmr_irq = 1'b1;
        wait_ack();
        tmr_irq = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_start(input logic [15:0] p, input logic [7:0] ps);
        int s;
        @(negedge clk);
        s = cyc;
        push_bus(3'd0, 8'h08, s + 1);
        push_bus(3'd6, ps, s + 2);
        push_bus(3'd4, p[7:0], s + 3);
        push_bus(3'd5, p[15:8], s + 4);
        push_bus(3'd0, 8'h07, s + 5);
        period   = p;
        prescale = ps;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_stop();
        push_bus(3'd0, 8'h00, cyc + 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int s;
        int run_snap;
        #1;
        chk("rst_outs", {19'd0, tmr_cs, tmr_write, tmr_addr, tmr_wdata, task_switch, running, cfg_err}, 32'd0);
        chk("rst_tid", {30'd0, task_id}, 32'd0);
        chk("rst_tick", {16'd0, tick_count}, 32'd0);
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        task_mask = 4'b1011;

        do_start(16'h0003, 8'h00);
        repeat (5) @(negedge clk);
        chk("running_after_cfg", {31'd0, running}, 32'd1);

        // start while running: no bus traffic, no cfg_err
        period = 16'h0005;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("start_in_run", {31'd0, running}, 32'd1);

        do_tick(1'b1, 2'd1);
        do_tick(1'b1, 2'd3);
        do_tick(1'b1, 2'd0);
        do_tick(1'b1, 2'd1);
        do_tick(1'b1, 2'd3);
        chk("tick5", {16'd0, tick_count}, 32'd5);
        chk("nsw5", n_sw, 32'd5);
        chk("tid3", {30'd0, task_id}, 32'd3);

        task_mask = 4'b0100;
        do_tick(1'b1, 2'd2);
        do_tick(1'b0, 2'd0);
        do_tick(1'b0, 2'd0);
        chk("tick8", {16'd0, tick_count}, 32'd8);
        chk("nsw_single", n_sw, 32'd6);
        task_mask = 4'b0000;
        do_tick(1'b0, 2'd0);
        chk("tick9", {16'd0, tick_count}, 32'd9);
        chk("nsw_zero", n_sw, 32'd6);
        chk("tid_hold", {30'd0, task_id}, 32'd2);

        do_stop();
        chk("idle_after_stop", {31'd0, running}, 32'd0);
        chk("tid_kept", {30'd0, task_id}, 32'd2);

        // stop during W_CMPL
        @(negedge clk);
        s        = cyc;
        run_snap = n_run;
        push_bus(3'd0, 8'h08, s + 1);
        push_bus(3'd6, 8'h11, s + 2);
        push_bus(3'd4, 8'h22, s + 3);
        push_bus(3'd5, 8'h00, s + 4);
        push_bus(3'd0, 8'h00, s + 5);
        period   = 16'h0022;
        prescale = 8'h11;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (4) @(negedge clk);
        chk("cmpl_stop_norun", n_run - run_snap, 32'd0);
        chk("cmpl_stop_tick", {16'd0, tick_count}, 32'd0);

        // period == 0 rejected
        period = 16'h0000;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("cfg_err_pulse", {31'd0, cfg_err}, 32'd1);
        @(negedge clk);
        chk("cfg_err_clear", {31'd0, cfg_err}, 32'd0);
        chk("cfg_err_idle", {31'd0, running}, 32'd0);

        // irq and stop together in RUN: no ACK write
        task_mask = 4'b1011;
        do_start(16'h1234, 8'h56);
        repeat (5) @(negedge clk);
        chk("running_2", {31'd0, running}, 32'd1);
        tmr_irq = 1'b1;
        do_stop();
        tmr_irq = 1'b0;
        chk("irq_stop_idle", {31'd0, running}, 32'd0);
        chk("irq_stop_tick", {16'd0, tick_count}, 32'd0);

        // reset during ACK
        task_mask = 4'b0011;
        do_start(16'h0010, 8'h02);
        repeat (5) @(negedge clk);
        do_tick(1'b1, 2'd0);
        chk("pre_rst_tick", {16'd0, tick_count}, 32'd1);
        push_bus(3'd1, 8'h01, -1);
        tmr_irq = 1'b1;
        wait_ack();
        #2 rst = 1'b1;
        #1;
        chk("arst_outs", {19'd0, tmr_cs, tmr_write, tmr_addr, tmr_wdata, task_switch, running, cfg_err}, 32'd0);
        chk("arst_tick", {16'd0, tick_count}, 32'd0);
        tmr_irq = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        task_mask = 4'b0110;
        do_start(16'h0004, 8'h00);
        repeat (5) @(negedge clk);
        chk("restart_run", {31'd0, running}, 32'd1);
        chk("restart_tick", {16'd0, tick_count}, 32'd0);
        do_tick(1'b1, 2'd1);
        chk("restart_tick1", {16'd0, tick_count}, 32'd1);
        do_stop();

        repeat (3) @(negedge clk);
        chk("bus_q_empty", bus_q.size(), 32'd0);
        chk("sw_q_empty", sw_q.size(), 32'd0);
        chk("cfg_err_count", n_cfg, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tick_sched_ctrl.md
TICK_SCHED_CTRL -- requirements
Module: tick_sched_ctrl

Interface
REQ-001 Parameter NUM_TASKS, default 4, sets the number of schedulable tasks (2..16).
REQ-002 Parameter TID_W, default 2, sets the task index width and SHALL equal clog2(NUM_TASKS).
REQ-003 clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 start  in  1  one-cycle request to configure and run the tick timer.
REQ-006 stop  in  1  one-cycle request to disable the timer and return to idle.
REQ-007 period  in  16  compare value written to the timer; sampled at accepted start.
REQ-008 prescale  in  8  prescaler value written to the timer; sampled at accepted start.
REQ-009 task_mask  in  NUM_TASKS  per-task enable; sampled live at each tick.
REQ-010 tmr_cs, tmr_write  out  1 each  timer register bus strobes, asserted together for one cycle per write.
REQ-011 tmr_addr  out  3  timer register address.
REQ-012 tmr_wdata  out  8  timer write data.
REQ-013 tmr_irq  in  1  timer interrupt, level, held until the status match bit is cleared.
REQ-014 task_id  out  TID_W  currently selected task.
REQ-015 task_switch  out  1  one-cycle pulse when task_id changes.
REQ-016 running  out  1  high in RUN, ACK and SWITCH states.
REQ-017 tick_count  out  16  number of serviced ticks since the last accepted start; wraps FFFF->0000.
REQ-018 cfg_err  out  1  one-cycle pulse when a start is rejected.

Function
REQ-019 The FSM states SHALL be IDLE, W_RST, W_PRE, W_CMPL, W_CMPH, W_EN, RUN, ACK, SWITCH and W_OFF.
REQ-020 In IDLE, start with period!=0 and stop=0 SHALL latch period and prescale, clear tick_count and go to W_RST.
REQ-021 In IDLE, start with period==0 SHALL pulse cfg_err next cycle and remain in IDLE; start with stop both high SHALL be ignored.
REQ-022 Each W_* state SHALL last exactly one cycle with tmr_cs=tmr_write=1: W_RST addr 0 data 0x08; W_PRE addr 6 data prescale; W_CMPL addr 4 data period[7:0]; W_CMPH addr 5 data period[15:8]; W_EN addr 0 data 0x07 (enable, continuous, int enable); W_OFF addr 0 data 0x00.
REQ-023 Sequence SHALL be W_RST->W_PRE->W_CMPL->W_CMPH->W_EN->RUN, so the first bus write occurs 1 cycle after start and W_EN occurs 5 cycles after start.
REQ-024 Outside W_* and ACK states, tmr_cs, tmr_write, tmr_addr and tmr_wdata SHALL be 0.
REQ-025 RUN: tmr_irq=1 SHALL move to ACK; stop=1 SHALL move to W_OFF, with stop taking priority over tmr_irq.
REQ-026 ACK SHALL write addr 1 data 0x01 (clear match) for one cycle, then go to SWITCH.
REQ-027 SWITCH SHALL increment tick_count and select the next task, then return to RUN.
REQ-028 Next task SHALL be the lowest index greater than task_id whose task_mask bit is set, wrapping to index 0 and upward.
REQ-029 If the only set bit is the current task_id, task_id SHALL be unchanged and task_switch SHALL stay low.
REQ-030 If task_mask==0, task_id SHALL hold and task_switch SHALL stay low; tick_count SHALL still increment.
REQ-031 task_switch SHALL pulse in the cycle after SWITCH, coincident with the new task_id.
REQ-032 A stop seen in any W_RST..W_EN, ACK or SWITCH state SHALL be latched. The current state SHALL complete, then the FSM SHALL go to W_OFF instead of its normal successor.
REQ-033 W_OFF SHALL go to IDLE; task_id SHALL be kept for the next run.
REQ-034 start outside IDLE SHALL be ignored without cfg_err.

Reset
REQ-035 rst=1 SHALL immediately force state IDLE, task_id=0, tick_count=0, stop latch clear, and all outputs 0, independent of clk.
REQ-036 rst asserted mid-sequence SHALL abort without a W_OFF write; the timer is reset by its own reset.

Verification
REQ-037 start with period=0x0003, prescale=0x00 -> bus writes (0,08),(6,00),(4,03),(5,00),(0,07) on consecutive cycles 1..5 after start.
REQ-038 Running with task_mask=4'b1011 and task_id=0, five ticks -> task_id sequence 1,3,0,1,3; five task_switch pulses; tick_count=5.
REQ-039 task_mask=4'b0100 with task_id=2 -> ticks increment tick_count and produce no task_switch; then mask=0 -> same.
REQ-040 stop asserted during W_CMPL -> W_CMPH completes, then (0,00) write, then IDLE; running never asserts.
REQ-041 start with period=0 -> cfg_err pulse, no bus activity; tmr_irq and stop in the same RUN cycle -> W_OFF, no ACK write.
REQ-042 rst pulsed during ACK -> outputs 0 asynchronously; a subsequent start restarts from W_RST with tick_count=0.
